// File: rtl/perceptron_trainer_pkg.sv
// Shared types for the perceptron trainer: sign-magnitude Q15.16 word,
// trainer FSM encoding and a packing helper that forbids negative zero.
package nn_pkg;

    localparam int SIGN  = 1;
    localparam int Q_M   = 15;
    localparam int Q_N   = 16;
    localparam int W     = SIGN + Q_M + Q_N;
    localparam int MAG_W = Q_M + Q_N;

    typedef logic [W-1:0]     fxp_t;
    typedef logic [MAG_W-1:0] fxp_mag_t;

    localparam fxp_mag_t FXP_MAG_MAX = {MAG_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        APPLY,
        SAMPLE,
        EPOCH_END,
        DONE
    } trainer_state_t;

    // A zero magnitude always carries a positive sign.
    function automatic fxp_t fxp_pack(input logic sign, input fxp_mag_t mag);
        return {sign & (mag != '0), mag};
    endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Bundle between the trainer and its environment (host start + neuron loop).
// start is a one-cycle request accepted only in IDLE; done is a one-cycle
// completion pulse; busy covers LOAD through EPOCH_END; state_dbg mirrors the FSM.
interface perceptron_trainer_if;
    import nn_pkg::*;

    logic           start;
    logic           y_in;
    logic           x1_out;
    logic           x2_out;
    fxp_t           w1_out;
    fxp_t           w2_out;
    fxp_t           wb_out;
    logic           busy;
    logic           done;
    logic           converged;
    logic [7:0]     epochs_out;
    trainer_state_t state_dbg;

    modport master (
        output start, y_in,
        input  x1_out, x2_out, w1_out, w2_out, wb_out,
        input  busy, done, converged, epochs_out, state_dbg
    );

    modport slave (
        input  start, y_in,
        output x1_out, x2_out, w1_out, w2_out, wb_out,
        output busy, done, converged, epochs_out, state_dbg
    );

endinterface

// File: rtl/perceptron_trainer_step_sat.sv
// Combinational sign-magnitude step of one weight by +/-LR, with magnitude
// saturation and zero-sign normalisation; passes the weight through when idle.
module sm_step_sat
    import nn_pkg::*;
#(
    parameter fxp_t LR = 32'h0000_8000
) (
    input  fxp_t w_in,
    input  logic en,
    input  logic neg,
    output fxp_t w_out
);

    logic           w_sign;
    logic           s_sign;
    fxp_mag_t       w_mag;
    fxp_mag_t       s_mag;
    logic [MAG_W:0] sum;
    fxp_t           stepped;

    always_comb begin
        w_sign  = w_in[W-1];
        w_mag   = w_in[MAG_W-1:0];
        s_sign  = neg ^ LR[W-1];
        s_mag   = LR[MAG_W-1:0];
        sum     = {1'b0, w_mag} + {1'b0, s_mag};
        stepped = w_in;
        if (w_sign == s_sign) begin
            stepped = fxp_pack(w_sign, sum[MAG_W] ? FXP_MAG_MAX : sum[MAG_W-1:0]);
        end else if (w_mag >= s_mag) begin
            stepped = fxp_pack(w_sign, w_mag - s_mag);
        end else begin
            stepped = fxp_pack(s_sign, s_mag - w_mag);
        end
        w_out = en ? stepped : w_in;
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Training controller for a 2-input neuron: walks the truth table, samples
// the neuron output and applies the perceptron rule until an epoch is error-free.
module perceptron_trainer
    import nn_pkg::*;
#(
    parameter logic [3:0] TARGETS    = 4'b1000,
    parameter fxp_t       LR         = 32'h0000_8000,
    parameter fxp_t       INIT_W1    = 32'h0,
    parameter fxp_t       INIT_W2    = 32'h0,
    parameter fxp_t       INIT_WB    = 32'h0,
    parameter int         SETTLE     = 1,
    parameter int         MAX_EPOCHS = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    perceptron_trainer_if.slave  bus
);

    localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [8:0]       EPOCH_LIMIT = 9'(MAX_EPOCHS);

    trainer_state_t   state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       epoch_q, epoch_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    fxp_t             w1_q, w1_d;
    fxp_t             w2_q, w2_d;
    fxp_t             wb_q, wb_d;
    logic             converged_q, converged_d;
    logic [7:0]       epochs_q, epochs_d;

    logic             sample_err;
    fxp_t             w1_step, w2_step, wb_step;

    // e = TARGETS[idx] - y_in is nonzero exactly when they differ; its sign is -y_in.
    assign sample_err = (state_q == SAMPLE) && (TARGETS[idx_q] != bus.y_in);

    sm_step_sat #(.LR(LR)) u_step_w1 (
        .w_in  (w1_q),
        .en    (sample_err & idx_q[1]),
        .neg   (bus.y_in),
        .w_out (w1_step)
    );

    sm_step_sat #(.LR(LR)) u_step_w2 (
        .w_in  (w2_q),
        .en    (sample_err & idx_q[0]),
        .neg   (bus.y_in),
        .w_out (w2_step)
    );

    sm_step_sat #(.LR(LR)) u_step_wb (
        .w_in  (wb_q),
        .en    (sample_err),
        .neg   (bus.y_in),
        .w_out (wb_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            epoch_q     <= '0;
            err_q       <= 1'b0;
            settle_q    <= '0;
            w1_q        <= INIT_W1;
            w2_q        <= INIT_W2;
            wb_q        <= INIT_WB;
            converged_q <= 1'b0;
            epochs_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            epoch_q     <= epoch_d;
            err_q       <= err_d;
            settle_q    <= settle_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            wb_q        <= wb_d;
            converged_q <= converged_d;
            epochs_q    <= epochs_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        epoch_d     = epoch_q;
        err_d       = err_q;
        settle_d    = settle_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        wb_d        = wb_q;
        converged_d = converged_q;
        epochs_d    = epochs_q;

        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                w1_d        = INIT_W1;
                w2_d        = INIT_W2;
                wb_d        = INIT_WB;
                idx_d       = '0;
                epoch_d     = '0;
                err_d       = 1'b0;
                settle_d    = '0;
                converged_d = 1'b0;
                epochs_d    = '0;
                state_d     = APPLY;
            end
            APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE: begin
                // Step outputs equal the held weight when that weight is not updated.
                w1_d = w1_step;
                w2_d = w2_step;
                wb_d = wb_step;
                if (sample_err) err_d = 1'b1;
                if (idx_q == 2'd3) begin
                    state_d = EPOCH_END;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = APPLY;
                end
            end
            EPOCH_END: begin
                epochs_d = epoch_q + 8'd1;
                if (!err_q) begin
                    converged_d = 1'b1;
                    state_d     = DONE;
                end else if (({1'b0, epoch_q} + 9'd1) == EPOCH_LIMIT) begin
                    state_d = DONE;
                end else begin
                    epoch_d = epoch_q + 8'd1;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = APPLY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.x1_out = 1'b0;
        bus.x2_out = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state_q)
            LOAD: begin
                bus.busy = 1'b1;
            end
            APPLY, SAMPLE: begin
                bus.busy   = 1'b1;
                bus.x1_out = idx_q[1];
                bus.x2_out = idx_q[0];
            end
            EPOCH_END: begin
                bus.busy = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    assign bus.w1_out     = w1_q;
    assign bus.w2_out     = w2_q;
    assign bus.wb_out     = wb_q;
    assign bus.converged  = converged_q;
    assign bus.epochs_out = epochs_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: four trainer configurations (AND loop,
// XOR loop, saturation, sign crossing) with hand-computed expected results.
module tb_perceptron_trainer;
    import nn_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- neuron model ----------------
    function automatic longint sm_to_int(input fxp_t v);
        longint mag;
        mag = longint'(v[MAG_W-1:0]);
        return v[W-1] ? -mag : mag;
    endfunction

    function automatic logic neuron(input fxp_t w1, input fxp_t w2, input fxp_t wb,
                                    input logic x1, input logic x2);
        longint s;
        s = sm_to_int(wb);
        if (x1) s = s + sm_to_int(w1);
        if (x2) s = s + sm_to_int(w2);
        return s > 0;
    endfunction

    // ---------------- DUTs: 0=AND, 1=XOR, 2=saturation, 3=sign crossing ----------------
    perceptron_trainer_if if_and ();
    perceptron_trainer_if if_xor ();
    perceptron_trainer_if if_sat ();
    perceptron_trainer_if if_sgn ();

    perceptron_trainer u_and (.clk(clk), .rst_n(rst_n), .bus(if_and));

    perceptron_trainer #(.TARGETS(4'b0110), .MAX_EPOCHS(8))
        u_xor (.clk(clk), .rst_n(rst_n), .bus(if_xor));

    perceptron_trainer #(.TARGETS(4'b1111), .INIT_W1(32'h7FFF_C000), .MAX_EPOCHS(1))
        u_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat));

    perceptron_trainer #(.TARGETS(4'b0000), .INIT_W2(32'h0000_8000),
                         .INIT_WB(32'h0000_4000), .MAX_EPOCHS(1))
        u_sgn (.clk(clk), .rst_n(rst_n), .bus(if_sgn));

    logic [3:0]     start_v;
    logic [3:0]     done_v, busy_v, conv_v, x1_v, x2_v;
    fxp_t           w1_v [4];
    fxp_t           w2_v [4];
    fxp_t           wb_v [4];
    logic [7:0]     ep_v [4];
    trainer_state_t st_v [4];

    assign if_and.start = start_v[0];
    assign if_xor.start = start_v[1];
    assign if_sat.start = start_v[2];
    assign if_sgn.start = start_v[3];

    assign if_and.y_in = neuron(if_and.w1_out, if_and.w2_out, if_and.wb_out,
                                if_and.x1_out, if_and.x2_out);
    assign if_xor.y_in = neuron(if_xor.w1_out, if_xor.w2_out, if_xor.wb_out,
                                if_xor.x1_out, if_xor.x2_out);
    assign if_sat.y_in = 1'b0;
    assign if_sgn.y_in = 1'b1;

    assign done_v = {if_sgn.done, if_sat.done, if_xor.done, if_and.done};
    assign busy_v = {if_sgn.busy, if_sat.busy, if_xor.busy, if_and.busy};
    assign conv_v = {if_sgn.converged, if_sat.converged, if_xor.converged, if_and.converged};
    assign x1_v   = {if_sgn.x1_out, if_sat.x1_out, if_xor.x1_out, if_and.x1_out};
    assign x2_v   = {if_sgn.x2_out, if_sat.x2_out, if_xor.x2_out, if_and.x2_out};

    assign w1_v[0] = if_and.w1_out;  assign w1_v[1] = if_xor.w1_out;
    assign w1_v[2] = if_sat.w1_out;  assign w1_v[3] = if_sgn.w1_out;
    assign w2_v[0] = if_and.w2_out;  assign w2_v[1] = if_xor.w2_out;
    assign w2_v[2] = if_sat.w2_out;  assign w2_v[3] = if_sgn.w2_out;
    assign wb_v[0] = if_and.wb_out;  assign wb_v[1] = if_xor.wb_out;
    assign wb_v[2] = if_sat.wb_out;  assign wb_v[3] = if_sgn.wb_out;
    assign ep_v[0] = if_and.epochs_out;  assign ep_v[1] = if_xor.epochs_out;
    assign ep_v[2] = if_sat.epochs_out;  assign ep_v[3] = if_sgn.epochs_out;
    assign st_v[0] = if_and.state_dbg;   assign st_v[1] = if_xor.state_dbg;
    assign st_v[2] = if_sat.state_dbg;   assign st_v[3] = if_sgn.state_dbg;

    // ---------------- scoreboard ----------------
    int                n_checks = 0;
    int                n_err    = 0;
    logic [W-1:0]      exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected w1, w2, wb are queued in that order before calling.
    task automatic check_weights(input int k, input string tag);
        check({tag, "_w1"}, w1_v[k], exp_q.pop_front());
        check({tag, "_w2"}, w2_v[k], exp_q.pop_front());
        check({tag, "_wb"}, wb_v[k], exp_q.pop_front());
    endtask

    task automatic expect_weights(input fxp_t w1, input fxp_t w2, input fxp_t wb);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        exp_q.push_back(wb);
    endtask

    // ---------------- driver ----------------
    // Pulses start for DUT k; the start cycle is cycle 0 and cycle c is sampled
    // at the c-th falling edge afterwards. Returns the cycle in which done is
    // high, or -1 when a reset was injected at cycle rst_at.
    task automatic run(input int k, input int start_at, input int rst_at, output int cycles);
        int c;
        @(negedge clk);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        c = 1;
        while (!done_v[k] && c < 2000) begin
            if (c == start_at) start_v[k] = 1'b1;
            if (c == rst_at) rst_n = 1'b0;
            if (k == 3 && c == 6) begin
                check("sgn_mid_w2", w2_v[3], 32'h0000_0000);
                check("sgn_mid_wb", wb_v[3], 32'h8000_C000);
                check("sgn_mid_x1", {31'd0, x1_v[3]}, 32'd1);
            end
            @(negedge clk);
            start_v[k] = 1'b0;
            if (c == rst_at) begin
                rst_n  = 1'b1;
                cycles = -1;
                return;
            end
            c++;
        end
        if (c >= 2000) check("done_timeout", {31'd0, done_v[k]}, 32'd1);
        cycles = c;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        rst_n   = 1'b0;
        start_v = '0;
        repeat (3) @(negedge clk);

        check("rst_state",  32'(st_v[0]), 32'(IDLE));
        check("rst_busy",   {31'd0, busy_v[0]}, 32'd0);
        check("rst_done",   {31'd0, done_v[0]}, 32'd0);
        check("rst_conv",   {31'd0, conv_v[0]}, 32'd0);
        check("rst_epochs", {24'd0, ep_v[0]}, 32'd0);
        check("rst_x",      {30'd0, x1_v[0], x2_v[0]}, 32'd0);
        expect_weights(32'h0, 32'h0, 32'h0);
        check_weights(0, "rst_and");
        check("rst_sat_w1", w1_v[2], 32'h7FFF_C000);
        check("rst_sgn_wb", wb_v[3], 32'h0000_4000);
        rst_n = 1'b1;

        // start coinciding with reset must be dropped
        @(negedge clk);
        start_v[0] = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        rst_n      = 1'b1;
        check("rst_start_state", 32'(st_v[0]), 32'(IDLE));
        @(negedge clk);
        check("rst_start_busy", {31'd0, busy_v[0]}, 32'd0);

        // AND with closed-loop neuron
        run(0, -1, -1, cyc);
        check("and_cycles", cyc, 32'd56);
        check("and_conv",   {31'd0, conv_v[0]}, 32'd1);
        check("and_epochs", {24'd0, ep_v[0]}, 32'd6);
        check("and_busy_at_done", {31'd0, busy_v[0]}, 32'd0);
        expect_weights(32'h0001_0000, 32'h0000_8000, 32'h8001_0000);
        check_weights(0, "and");
        @(negedge clk);
        check("and_done_pulse", {31'd0, done_v[0]}, 32'd0);
        check("and_idle", 32'(st_v[0]), 32'(IDLE));
        repeat (3) @(negedge clk);
        expect_weights(32'h0001_0000, 32'h0000_8000, 32'h8001_0000);
        check_weights(0, "and_hold");
        check("and_hold_epochs", {24'd0, ep_v[0]}, 32'd6);
        check("and_hold_conv",   {31'd0, conv_v[0]}, 32'd1);

        // reset during epoch 2, then a clean rerun
        run(0, -1, 14, cyc);
        check("midrst_state",  32'(st_v[0]), 32'(IDLE));
        check("midrst_busy",   {31'd0, busy_v[0]}, 32'd0);
        check("midrst_epochs", {24'd0, ep_v[0]}, 32'd0);
        check("midrst_conv",   {31'd0, conv_v[0]}, 32'd0);
        expect_weights(32'h0, 32'h0, 32'h0);
        check_weights(0, "midrst");
        run(0, -1, -1, cyc);
        check("rerun_cycles", cyc, 32'd56);
        check("rerun_epochs", {24'd0, ep_v[0]}, 32'd6);
        expect_weights(32'h0001_0000, 32'h0000_8000, 32'h8001_0000);
        check_weights(0, "rerun");

        // start pulsed mid-training (epoch 3) has no effect
        run(0, 22, -1, cyc);
        check("busystart_cycles", cyc, 32'd56);
        check("busystart_conv",   {31'd0, conv_v[0]}, 32'd1);
        check("busystart_epochs", {24'd0, ep_v[0]}, 32'd6);
        expect_weights(32'h0001_0000, 32'h0000_8000, 32'h8001_0000);
        check_weights(0, "busystart");

        // XOR never converges: stops at the epoch limit
        run(1, -1, -1, cyc);
        check("xor_cycles", cyc, 32'd74);
        check("xor_conv",   {31'd0, conv_v[1]}, 32'd0);
        check("xor_epochs", {24'd0, ep_v[1]}, 32'd8);
        @(negedge clk);
        check("xor_busy_after", {31'd0, busy_v[1]}, 32'd0);
        check("xor_idle", 32'(st_v[1]), 32'(IDLE));

        // magnitude saturation on w1
        run(2, -1, -1, cyc);
        check("sat_cycles", cyc, 32'd11);
        check("sat_conv",   {31'd0, conv_v[2]}, 32'd0);
        check("sat_epochs", {24'd0, ep_v[2]}, 32'd1);
        expect_weights(32'h7FFF_FFFF, 32'h0001_0000, 32'h0002_0000);
        check_weights(2, "sat");

        // crossing zero: no negative zero, then negative results
        run(3, -1, -1, cyc);
        check("sgn_cycles", cyc, 32'd11);
        check("sgn_conv",   {31'd0, conv_v[3]}, 32'd0);
        check("sgn_epochs", {24'd0, ep_v[3]}, 32'd1);
        expect_weights(32'h8001_0000, 32'h8000_8000, 32'h8001_C000);
        check_weights(3, "sgn");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
